// File: rtl/pc_unit.sv
// Program counter with relative branch, absolute jump/call and return-address stack.
// Latency: every action lands on pc one clock after the requesting edge; pc_next/link are combinational.
// Backpressure: stall holds pc and stack for the cycle; status pulses drop low during a stall.
//
// Optional feature macro: PC_RAS_EN (return-address stack, ras_ovf/ras_unf). Undefined: call acts
// as jmp, ret acts as a sequential step, ras_ovf/ras_unf are tied low.
//
// Ports: clk, rst_n (sync, active-low) | stall, br_take, br_off, jmp, call, jmp_addr, ret (requests)
//        pc (registered), pc_next (comb), link (comb pc+STEP), misalign/ras_ovf/ras_unf (registered pulses)
module pc_unit #(
    parameter int                 ADDR_W     = 16,
    parameter int                 OFF_W      = 8,
    parameter int                 STEP       = 2,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
    parameter int                 RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_take,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              jmp,
    input  logic              call,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] link,
    output logic              misalign,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic              ras_ovf_q, ras_ovf_d;
    logic              ras_unf_q, ras_unf_d;
    logic [ADDR_W-1:0] seq_pc, br_pc, tgt_pc, off_ext;

    assign seq_pc  = pc_q + STEP_A;
    // Offset is in instructions: sign-extend to address width, then scale by STEP.
    assign off_ext = {{(ADDR_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign br_pc   = seq_pc + off_ext * STEP_A;
    assign tgt_pc  = {jmp_addr[ADDR_W-1:1], 1'b0};

`ifdef PC_RAS_EN
    localparam int                PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);

    // sp_q points at the next slot to write; when full it also points at the oldest
    // entry, so a push there overwrites the oldest return address.
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d, top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    assign top_idx = sp_q - PTR_ONE;
`endif

    always_comb begin
        pc_d       = seq_pc;
        misalign_d = 1'b0;
        ras_ovf_d  = 1'b0;
        ras_unf_d  = 1'b0;
`ifdef PC_RAS_EN
        push       = 1'b0;
        pop        = 1'b0;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
`endif
        if (!rst_n) begin
            pc_d = RESET_ADDR;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
`ifdef PC_RAS_EN
            if (cnt_q != '0) begin
                pc_d  = ras_q[top_idx];
                pop   = 1'b1;
                sp_d  = top_idx;
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                ras_unf_d = 1'b1;
            end
`else
            pc_d = seq_pc;
`endif
        end else if (call || jmp) begin
            pc_d       = tgt_pc;
            misalign_d = jmp_addr[0];
`ifdef PC_RAS_EN
            if (call) begin
                push      = 1'b1;
                sp_d      = sp_q + PTR_ONE;
                ras_ovf_d = (cnt_q == CNT_FULL);
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
        end else if (br_take) begin
            pc_d = br_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_ADDR;
            misalign_q <= 1'b0;
            ras_ovf_q  <= 1'b0;
            ras_unf_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            ras_ovf_q  <= ras_ovf_d;
            ras_unf_q  <= ras_unf_d;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage needs no reset: a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            ras_q[sp_q] <= seq_pc;
        end
    end

    assign ras_ovf = ras_ovf_q;
    assign ras_unf = ras_unf_q;
`else
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

    assign pc       = pc_q;
    assign pc_next  = pc_d;
    assign link     = seq_pc;
    assign misalign = misalign_q;

endmodule
